// File: rtl/mfda_ctrl_pkg.sv
// Shared types and default sizing for the control/flush pad sequencer.
package mfda_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_SET_MASK  = 2'd0,
        OP_PUMP      = 2'd1,
        OP_FLUSH_ALL = 2'd2,
        OP_RSVD      = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_PUMP       = 2'd1,
        S_FLUSH_WAIT = 2'd2
    } seq_state_e;

    localparam int unsigned DEF_N_CTRL    = 13;
    localparam int unsigned DEF_N_PUMP    = 3;
    localparam int unsigned DEF_CNT_W     = 16;
    localparam int unsigned DEF_FLUSH_CYC = 8;

endpackage

// File: rtl/ctrl_flush_timer.sv
// Per-line vent timer: load starts a FLUSH_CYC pulse, clear kills it at once.
module ctrl_flush_timer #(
    parameter int unsigned FLUSH_CYC = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    output logic active
);

    localparam int unsigned TW = $clog2(FLUSH_CYC + 1);

    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_nxt;

    // Load wins over clear; otherwise count down to zero and hold.
    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = TW'(FLUSH_CYC);
        end else if (clear) begin
            cnt_nxt = '0;
        end else if (cnt != '0) begin
            cnt_nxt = cnt - TW'(1);
        end
    end

    // Counter and registered active flag track the same next value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            active <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            active <= (cnt_nxt != '0);
        end
    end

endmodule

// File: rtl/ctrl_pad_sequencer.sv
// Command-driven sequencer for control pads, auto-vent flush pads and a peristaltic pump group.
module ctrl_pad_sequencer
    import mfda_ctrl_pkg::*;
#(
    parameter int unsigned N_CTRL    = DEF_N_CTRL,
    parameter int unsigned N_PUMP    = DEF_N_PUMP,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned FLUSH_CYC = DEF_FLUSH_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [N_CTRL-1:0] cmd_mask,
    input  logic [CNT_W-1:0]  cmd_arg,
    input  logic [CNT_W-1:0]  pump_period,
    output logic [N_CTRL-1:0] ctrl_out,
    output logic [N_CTRL-1:0] flush_out,
    output logic [N_PUMP-1:0] pump_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned PH_W = (N_PUMP > 1) ? $clog2(N_PUMP) : 1;

    seq_state_e        state, state_nxt;
    cmd_op_e           op;
    logic [PH_W-1:0]   phase, phase_nxt;
    logic [CNT_W-1:0]  per_cnt, per_cnt_nxt;
    logic [CNT_W-1:0]  per_lim, per_lim_nxt;
    logic [CNT_W-1:0]  strokes, strokes_nxt;
    logic [N_CTRL-1:0] ctrl_nxt;
    logic [N_PUMP-1:0] pump_nxt;
    logic              done_nxt;
    logic              err_nxt;
    logic              load_all;
    logic [N_CTRL-1:0] tmr_load;
    logic [N_CTRL-1:0] tmr_clear;

    assign op = cmd_op_e'(cmd_op);

    // Phase k closes valve k and its neighbour (k+1) mod N_PUMP.
    function automatic logic [N_PUMP-1:0] phase_pattern(input logic [PH_W-1:0] k);
        logic [N_PUMP-1:0] p;
        int unsigned       kn;
        kn = (32'(k) + 32'd1) % N_PUMP;
        p = '0;
        p[k]  = 1'b1;
        p[kn] = 1'b1;
        return p;
    endfunction

    // Next-state, counter and output decode.
    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        per_cnt_nxt = per_cnt;
        per_lim_nxt = per_lim;
        strokes_nxt = strokes;
        ctrl_nxt    = ctrl_out;
        pump_nxt    = pump_out;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        load_all    = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (op)
                        OP_SET_MASK: begin
                            ctrl_nxt = cmd_mask;
                            done_nxt = 1'b1;
                        end
                        OP_PUMP: begin
                            if (cmd_arg == '0) begin
                                err_nxt = 1'b1;
                            end else begin
                                state_nxt   = S_PUMP;
                                phase_nxt   = '0;
                                per_cnt_nxt = '0;
                                per_lim_nxt = (pump_period == '0) ? CNT_W'(1) : pump_period;
                                strokes_nxt = cmd_arg;
                                pump_nxt    = phase_pattern(PH_W'(0));
                            end
                        end
                        OP_FLUSH_ALL: begin
                            ctrl_nxt  = '0;
                            load_all  = 1'b1;
                            state_nxt = S_FLUSH_WAIT;
                        end
                        default: begin
                            err_nxt = 1'b1;
                        end
                    endcase
                end
            end
            S_PUMP: begin
                if (per_cnt == per_lim - CNT_W'(1)) begin
                    per_cnt_nxt = '0;
                    if (phase == PH_W'(N_PUMP - 1)) begin
                        phase_nxt = '0;
                        if (strokes == CNT_W'(1)) begin
                            state_nxt = S_IDLE;
                            pump_nxt  = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            strokes_nxt = strokes - CNT_W'(1);
                            pump_nxt    = phase_pattern(PH_W'(0));
                        end
                    end else begin
                        phase_nxt = phase + PH_W'(1);
                        pump_nxt  = phase_pattern(phase + PH_W'(1));
                    end
                end else begin
                    per_cnt_nxt = per_cnt + CNT_W'(1);
                end
            end
            S_FLUSH_WAIT: begin
                if (flush_out == '0) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Falling ctrl bits start a vent; any pressurised bit kills its vent on the same edge.
    always_comb begin
        tmr_load  = '0;
        tmr_clear = '0;
        for (int i = 0; i < int'(N_CTRL); i++) begin
            tmr_load[i]  = load_all | (ctrl_out[i] & ~ctrl_nxt[i]);
            tmr_clear[i] = ctrl_nxt[i];
        end
    end

    for (genvar g = 0; g < int'(N_CTRL); g++) begin : g_flush
        ctrl_flush_timer #(
            .FLUSH_CYC (FLUSH_CYC)
        ) u_timer (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (tmr_load[g]),
            .clear  (tmr_clear[g]),
            .active (flush_out[g])
        );
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase     <= '0;
            per_cnt   <= '0;
            per_lim   <= '0;
            strokes   <= '0;
            ctrl_out  <= '0;
            pump_out  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            per_cnt   <= per_cnt_nxt;
            per_lim   <= per_lim_nxt;
            strokes   <= strokes_nxt;
            ctrl_out  <= ctrl_nxt;
            pump_out  <= pump_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            cmd_ready <= (state_nxt == S_IDLE);
            busy      <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_ctrl_pad_sequencer.sv
// Directed bench for ctrl_pad_sequencer with a time-based reference model feeding an expectation queue.
module tb_ctrl_pad_sequencer;
    import mfda_ctrl_pkg::*;

    localparam int unsigned N_CTRL    = 13;
    localparam int unsigned N_PUMP    = 3;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned FLUSH_CYC = 8;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [N_CTRL-1:0] cmd_mask;
    logic [CNT_W-1:0]  cmd_arg;
    logic [CNT_W-1:0]  pump_period;
    logic [N_CTRL-1:0] ctrl_out;
    logic [N_CTRL-1:0] flush_out;
    logic [N_PUMP-1:0] pump_out;
    logic              busy;
    logic              done;
    logic              err;

    ctrl_pad_sequencer #(
        .N_CTRL    (N_CTRL),
        .N_PUMP    (N_PUMP),
        .CNT_W     (CNT_W),
        .FLUSH_CYC (FLUSH_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_mask    (cmd_mask),
        .cmd_arg     (cmd_arg),
        .pump_period (pump_period),
        .ctrl_out    (ctrl_out),
        .flush_out   (flush_out),
        .pump_out    (pump_out),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_CTRL-1:0] ctrl;
        logic [N_CTRL-1:0] flush;
        logic [N_PUMP-1:0] pump;
        logic              ready;
        logic              busy;
        logic              done;
        logic              err;
    } obs_t;

    obs_t        exp_q[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    string       tag         = "init";

    // Reference model: 0 idle, 1 pumping, 2 waiting for flush.
    int                m_state;
    logic [N_CTRL-1:0] m_ctrl;
    int                m_tmr[N_CTRL];
    int                m_t;
    int                m_arg;
    int                m_per;

    function automatic obs_t observe();
        obs_t o;
        o.ctrl  = ctrl_out;
        o.flush = flush_out;
        o.pump  = pump_out;
        o.ready = cmd_ready;
        o.busy  = busy;
        o.done  = done;
        o.err   = err;
        return o;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_ctrl  = '0;
        m_t     = 0;
        m_arg   = 0;
        m_per   = 1;
        for (int i = 0; i < int'(N_CTRL); i++) m_tmr[i] = 0;
        exp_q.delete();
    endtask

    // Predict outputs after the coming edge from the inputs now driven.
    task automatic model_step();
        int                st_n;
        logic [N_CTRL-1:0] ctrl_n;
        logic              ld_all;
        logic              all_idle;
        int                k;
        obs_t              e;
        st_n   = m_state;
        ctrl_n = m_ctrl;
        ld_all = 1'b0;
        e      = '0;
        all_idle = 1'b1;
        for (int i = 0; i < int'(N_CTRL); i++) if (m_tmr[i] != 0) all_idle = 1'b0;
        if (cmd_valid && m_state == 0) begin
            case (cmd_op)
                2'd0: begin
                    ctrl_n = cmd_mask;
                    e.done = 1'b1;
                end
                2'd1: begin
                    if (cmd_arg == '0) begin
                        e.err = 1'b1;
                    end else begin
                        st_n  = 1;
                        m_t   = 0;
                        m_arg = int'(cmd_arg);
                        m_per = (pump_period == '0) ? 1 : int'(pump_period);
                    end
                end
                2'd2: begin
                    ctrl_n = '0;
                    ld_all = 1'b1;
                    st_n   = 2;
                end
                default: e.err = 1'b1;
            endcase
        end else if (m_state == 1) begin
            m_t++;
            if (m_t == m_arg * int'(N_PUMP) * m_per) begin
                st_n   = 0;
                e.done = 1'b1;
            end
        end else if (m_state == 2) begin
            if (all_idle) begin
                st_n   = 0;
                e.done = 1'b1;
            end
        end
        for (int i = 0; i < int'(N_CTRL); i++) begin
            if (ld_all || (m_ctrl[i] && !ctrl_n[i])) m_tmr[i] = int'(FLUSH_CYC);
            else if (ctrl_n[i]) m_tmr[i] = 0;
            else if (m_tmr[i] > 0) m_tmr[i]--;
            e.flush[i] = (m_tmr[i] != 0);
        end
        if (st_n == 1) begin
            k = (m_t / m_per) % int'(N_PUMP);
            e.pump[k] = 1'b1;
            e.pump[(k + 1) % int'(N_PUMP)] = 1'b1;
        end
        e.ctrl  = ctrl_n;
        e.ready = (st_n == 0);
        e.busy  = (st_n != 0);
        m_state = st_n;
        m_ctrl  = ctrl_n;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        obs_t got;
        obs_t e;
        got = observe();
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: no expected entry queued, got %h", tag, got);
            return;
        end
        e = exp_q.pop_front();
        assert (got === e) else begin
            miscompares++;
            $error("FAIL %s: got ctrl=%h flush=%h pump=%b rdy=%b busy=%b done=%b err=%b, want ctrl=%h flush=%h pump=%b rdy=%b busy=%b done=%b err=%b",
                   tag, got.ctrl, got.flush, got.pump, got.ready, got.busy, got.done, got.err,
                   e.ctrl, e.flush, e.pump, e.ready, e.busy, e.done, e.err);
        end
        vectors++;
        assert ((ctrl_out & flush_out) === '0) else begin
            miscompares++;
            $error("FAIL %s interlock: ctrl&flush=%h, want 0", tag, ctrl_out & flush_out);
        end
    endtask

    task automatic check_reset(input string t);
        obs_t r;
        obs_t got;
        r = '0;
        r.ready = 1'b1;
        got = observe();
        vectors++;
        assert (got === r) else begin
            miscompares++;
            $error("FAIL %s: got %h, want %h", t, got, r);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic send(input logic [1:0] op, input logic [N_CTRL-1:0] mask,
                        input logic [CNT_W-1:0] arg, input logic [CNT_W-1:0] per);
        cmd_op      = op;
        cmd_mask    = mask;
        cmd_arg     = arg;
        pump_period = per;
        cmd_valid   = 1'b1;
        cycle();
        cmd_valid   = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'd0;
        cmd_mask    = '0;
        cmd_arg     = '0;
        pump_period = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        tag = "set_mask_release";
        send(2'd0, 13'h0005, '0, '0);
        send(2'd0, 13'h0004, '0, '0);
        idle(10);

        tag = "pump_2x3";
        send(2'd1, '0, 16'd2, 16'd3);
        idle(20);

        tag = "pump_arg0";
        send(2'd1, '0, 16'd0, 16'd5);
        idle(2);
        tag = "op_rsvd";
        send(2'd3, 13'h1ABC, 16'd7, 16'd1);
        idle(2);
        tag = "pump_period0";
        send(2'd1, '0, 16'd1, 16'd0);
        idle(4);

        tag = "repressurise";
        send(2'd0, 13'h0008, '0, '0);
        idle(2);
        send(2'd0, 13'h0000, '0, '0);
        idle(3);
        send(2'd0, 13'h0008, '0, '0);
        idle(10);

        tag = "flush_all";
        send(2'd0, 13'h1FFF, '0, '0);
        idle(1);
        send(2'd2, '0, '0, '0);
        cmd_op    = 2'd0;
        cmd_mask  = 13'h1234;
        cmd_valid = 1'b1;
        idle(8);
        cmd_valid = 1'b0;
        idle(4);

        tag = "pump_then_reset";
        send(2'd1, '0, 16'd5, 16'd2);
        idle(8);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("reset_mid_pump");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        tag = "after_reset";
        idle(4);
        send(2'd0, 13'h0003, '0, '0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
